sd_byte_fifo: RTL and testbench

Byte buffer directly downstream of the SD card SPI reader.
- Captures each deserialized data byte, announced by the reader's RCO strobe, into a circular FIFO.
- Presents bytes first-word-fall-through to the consumer (display/memory writer) with pop handshake.
- Tracks 512-byte block boundaries.
- Flags overflow/underflow so the reader's missing "push to FIFO" step has a defined sink.

---
 rtl/sd_byte_fifo.sv | 112 +++++++++++
 tb/tb_sd_byte_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sd_byte_fifo.sv
// sd_byte_fifo: byte buffer behind the SD card SPI reader.
// Each rising edge of the reader's strobe captures one byte into a circular
// FIFO. The head byte is presented first-word-fall-through to the consumer.
// The block also counts 512-byte block boundaries and keeps sticky
// overflow/underflow flags.
module sd_byte_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int BLOCK_BYTES = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  block_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BW    = $clog2(BLOCK_BYTES) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [BW-1:0]         blk_cnt;
  logic                  push_q;
  logic                  push_rise, pop_ok, wr_ok;

  // The strobe level can last several clocks, so only its rising edge writes.
  // A full FIFO still accepts a write when a pop frees a slot in the same
  // cycle. Writes are suppressed while reset or clear is active, so nothing
  // is left half-written.
  always_comb begin
    push_rise = push & ~push_q;
    pop_ok    = pop & ~empty;
    wr_ok     = push_rise & ~clear & ~reset & (~full | pop_ok);
  end

  assign empty    = (count == '0);
  assign full     = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign data_out = mem[rptr];

  // Storage array. It has no reset; stale contents are hidden behind count.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wptr] <= data_in;
  end

  // Pointers, occupancy and the strobe edge register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      push_q <= 1'b0;
    end else if (clear) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= push;
      if (wr_ok)  wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      if (wr_ok && !pop_ok)      count <= count + 1'b1;
      else if (!wr_ok && pop_ok) count <= count - 1'b1;
    end
  end

  // Sticky error flags. A dropped strobe edge sets overflow. A pop while
  // empty sets underflow. A write in the same cycle never satisfies that pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_rise && full && !pop_ok) overflow  <= 1'b1;
      if (pop && empty)                 underflow <= 1'b1;
    end
  end

  // Block boundary tracker. It counts only accepted writes and pulses once
  // per BLOCK_BYTES writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_cnt    <= '0;
      block_done <= 1'b0;
    end else if (clear) begin
      blk_cnt    <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      if (wr_ok) begin
        if (blk_cnt == BW'(BLOCK_BYTES - 1)) begin
          blk_cnt    <= '0;
          block_done <= 1'b1;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_byte_fifo.sv
// Self-checking bench for sd_byte_fifo. A queue-based reference model is
// compared every cycle, and directed scenarios pin literal expectations.
module tb_sd_byte_fifo;

  localparam int DEPTH = 1024;
  localparam int BLK   = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        push  = 1'b0;
  logic [7:0]  data_in = '0;
  logic        pop   = 1'b0;
  logic [7:0]  data_out;
  logic        empty, full, overflow, underflow, block_done;
  logic [10:0] count;

  sd_byte_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .BLOCK_BYTES(BLK)) dut (
    .clock(clock), .reset(reset), .clear(clear), .push(push),
    .data_in(data_in), .pop(pop), .data_out(data_out), .empty(empty),
    .full(full), .count(count), .overflow(overflow),
    .underflow(underflow), .block_done(block_done)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model: the FIFO contents are a queue of bytes.
  logic [7:0] q[$];
  bit m_push_q, m_ovf, m_unf, m_bdone;
  int m_blk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    q.delete();
    m_push_q = 0; m_ovf = 0; m_unf = 0; m_bdone = 0; m_blk = 0;
  endtask

  // Apply one clock edge of the model using the inputs currently applied.
  task automatic mdl_edge();
    bit rise, pok, wr;
    if (reset || clear) begin
      mdl_reset();
      return;
    end
    rise = push && !m_push_q;
    pok  = pop && (q.size() != 0);
    wr   = rise && ((q.size() < DEPTH) || pok);
    m_bdone = 0;
    if (pop && q.size() == 0) m_unf = 1;
    if (rise && !wr) m_ovf = 1;
    if (pok) void'(q.pop_front());
    if (wr) begin
      q.push_back(data_in);
      m_blk++;
      if (m_blk == BLK) begin
        m_blk = 0;
        m_bdone = 1;
      end
    end
    m_push_q = push;
  endtask

  // Drive one cycle. Inputs change 1 time unit after the active edge.
  task automatic step(input bit p, input logic [7:0] d, input bit po, input bit cl = 0);
    push = p; data_in = d; pop = po; clear = cl;
    @(posedge clock);
    mdl_edge();
    #1;
  endtask

  // One write: strobe high for `hold` clocks, then low for one clock.
  task automatic push_byte(input logic [7:0] d, input int hold = 1);
    for (int i = 0; i < hold; i++) step(1, d, 0);
    step(0, 8'h00, 0);
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clock) begin
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("block_done", 32'(block_done), 32'(m_bdone));
    if (q.size() != 0) chk("data_out", 32'(data_out), 32'(q[0]));
    if (block_done) pulses++;
  end

  initial begin
    logic [7:0] exp3 [3];
    int p0;
    bit p;
    int pct;
    exp3[0] = 8'hA1; exp3[1] = 8'hB2; exp3[2] = 8'hC3;

    reset = 1; mdl_reset();
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    #1;

    // Three writes, each with the strobe held high for 4 clocks.
    push_byte(8'hA1, 4); push_byte(8'hB2, 4); push_byte(8'hC3, 4);
    chk("three_count", 32'(count), 32'd3);
    chk("three_head", 32'(data_out), 32'hA1);
    for (int i = 0; i < 3; i++) begin
      chk("three_pop", 32'(data_out), 32'(exp3[i]));
      step(0, 8'h00, 1);
    end
    chk("three_empty", 32'(empty), 32'd1);

    // Fill from a clean state. Expect two block pulses, then one dropped write.
    step(0, 8'h00, 0, 1);
    p0 = pulses;
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    step(0, 8'h00, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd1024);
    chk("fill_pulses", 32'(pulses - p0), 32'd2);
    push_byte(8'hEE);
    step(0, 8'h00, 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd1024);
    chk("ovf_head", 32'(data_out), 32'h00);
    chk("ovf_no_pulse", 32'(pulses - p0), 32'd2);

    // Write and pop together while full: the byte goes to the tail.
    step(1, 8'h5A, 1);
    step(0, 8'h00, 0);
    chk("fullrw_count", 32'(count), 32'd1024);
    chk("fullrw_full", 32'(full), 32'd1);
    for (int i = 0; i < 1023; i++) step(0, 8'h00, 1);
    chk("fullrw_last", 32'(data_out), 32'h5A);
    step(0, 8'h00, 1);

    // Pop while empty. Then pop together with a write.
    step(0, 8'h00, 1);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    step(1, 8'h77, 1);
    chk("unf_rw_count", 32'(count), 32'd1);
    chk("unf_rw_head", 32'(data_out), 32'h77);
    step(0, 8'h00, 0);

    // Synchronous clear with data stored and a flag set.
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
    step(0, 8'h00, 0, 1);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_unf", 32'(underflow), 32'd0);
    push_byte(8'hE5);
    chk("clr_next", 32'(data_out), 32'hE5);

    // Asynchronous reset in the middle of a write strobe.
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    push = 1; data_in = 8'h99;
    #2 reset = 1; mdl_reset();
    #1 chk("arst_count", 32'(count), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    @(posedge clock); #1 reset = 0;
    // The strobe is still high after reset, so the model sees a rising edge.
    step(1, 8'h42, 0);
    chk("arst_rise", 32'(data_out), 32'h42);
    step(0, 8'h00, 0);

    // Random traffic, checked every cycle against the model.
    p = 0;
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 5 : (ph == 1) ? 60 : 30;
      for (int c = 0; c < 2000; c++) begin
        if ($urandom_range(0, 1) == 0) p = ~p;
        step(p, 8'($urandom), ($urandom_range(0, 99) < pct),
             ($urandom_range(0, 999) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
